// File: rtl/jc_chain_sequencer_if.sv
// -----------------------------------------------------------------------------
// jc_chain_sequencer_if
//
// Control/status bundle between the lab control logic (master) and the
// Johnson-chain run/stop sequencer (slave).
//
// Parameters:
//   NSTAGE  number of cascaded 4-bit Johnson stages (1..4)
//   PRE_W   prescaler divide field width
//   CNT_W   chain-cycle counter width
//
// Signals (direction seen from the sequencer):
//   start     in   start / resume request
//   stop      in   pause / abort request
//   step      in   single tick while paused (only when SEQ_STEP_EN is defined)
//   pre_div   in   tick period minus 1, read live
//   n_cycles  in   chain cycles to run, 0 = free-run
//   Q         out  chain state, stage k in Q[4k+3:4k]
//   tick      out  stage-0 count enable for the current cycle
//   cyc_ev    out  last-stage carry for the current cycle
//   cycles    out  completed chain cycles
//   busy      out  sequencer in RUN or HOLD
//   done      out  sequencer in DONE
//
// Build option: SEQ_STEP_EN adds the step signal.
// -----------------------------------------------------------------------------
interface jc_chain_sequencer_if #(
  parameter int NSTAGE = 2,
  parameter int PRE_W  = 8,
  parameter int CNT_W  = 8
);
  logic                start;
  logic                stop;
`ifdef SEQ_STEP_EN
  logic                step;
`endif
  logic [PRE_W-1:0]    pre_div;
  logic [CNT_W-1:0]    n_cycles;
  logic [4*NSTAGE-1:0] Q;
  logic                tick;
  logic                cyc_ev;
  logic [CNT_W-1:0]    cycles;
  logic                busy;
  logic                done;

  modport master (
    output start, stop,
`ifdef SEQ_STEP_EN
    output step,
`endif
    output pre_div, n_cycles,
    input  Q, tick, cyc_ev, cycles, busy, done
  );

  modport slave (
    input  start, stop,
`ifdef SEQ_STEP_EN
    input  step,
`endif
    input  pre_div, n_cycles,
    output Q, tick, cyc_ev, cycles, busy, done
  );
endinterface

// File: rtl/jc_chain_sequencer.sv
// -----------------------------------------------------------------------------
// jc_chain_sequencer
//
// Run/stop controller for a cascade of NSTAGE 4-bit Johnson counter stages.
// A programmable prescaler produces the stage-0 enable; each later stage is
// enabled by the carry of the stage before it. Completed chain cycles are
// counted and the sequencer stops after n_cycles of them (0 = free-run).
//
// Ports:
//   clk   clock, all state changes on the rising edge
//   clr   asynchronous active-high reset
//   bus   jc_chain_sequencer_if.slave (start/stop/step/pre_div/n_cycles in,
//         Q/tick/cyc_ev/cycles/busy/done out)
//
// Build option: SEQ_STEP_EN -- when defined, a step pulse in HOLD advances the
// chain by one tick; when undefined there is no step input and HOLD never
// ticks.
// -----------------------------------------------------------------------------
module jc_chain_sequencer #(
  parameter int NSTAGE = 2,
  parameter int PRE_W  = 8,
  parameter int CNT_W  = 8
) (
  input  logic                clk,
  input  logic                clr,
  jc_chain_sequencer_if.slave bus
);

  localparam int QW = 4 * NSTAGE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [QW-1:0]    q, q_nxt, q_adv;
  logic [PRE_W-1:0] pre_cnt, pre_nxt;
  logic [CNT_W-1:0] cycles, cycles_nxt, cycles_inc;
  logic             tick_en;
  logic             cyc_hit;
  logic             step_req;
  logic             start_req;

  function automatic logic [3:0] johnson_next(input logic [3:0] s);
    return {s[2:0], ~s[3]};
  endfunction

  // stop outranks start, and both outrank step.
  assign start_req = bus.start & ~bus.stop;

`ifdef SEQ_STEP_EN
  assign step_req = bus.step & ~bus.stop & ~bus.start;
`else
  assign step_req = 1'b0;
`endif

  assign cycles_inc = cycles + 1'b1;

  // ---------------------------------------------------------------------------
  // Stage-0 enable. A stop in RUN freezes everything on that same edge, so it
  // also suppresses the tick. The >= compare lets a live lowering of pre_div
  // below the running count fire immediately instead of waiting for a wrap.
  // ---------------------------------------------------------------------------
  always_comb begin
    tick_en = 1'b0;
    unique case (state)
      RUN:     tick_en = ~bus.stop & (pre_cnt >= bus.pre_div);
      HOLD:    tick_en = step_req;
      default: tick_en = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Carry ripple through the stages. ce_run starts as the stage-0 enable and
  // is ANDed with each stage's terminal state on the way up, so after the
  // last stage it is the chain-cycle event.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic ce_run;
    q_adv  = q;
    ce_run = tick_en;
    for (int k = 0; k < NSTAGE; k++) begin
      if (ce_run) q_adv[4*k +: 4] = johnson_next(q[4*k +: 4]);
      ce_run = ce_run & (q[4*k +: 4] == 4'hF);
    end
    cyc_hit = ce_run;
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath update.
  // ---------------------------------------------------------------------------
  // NOTE: every variable is given its hold value first so that no path through
  // the case statement leaves one unassigned, which would infer a latch.
  always_comb begin
    state_nxt  = state;
    q_nxt      = q;
    pre_nxt    = pre_cnt;
    cycles_nxt = cycles;

    unique case (state)
      IDLE: begin
        if (start_req) begin
          state_nxt  = RUN;
          q_nxt      = '0;
          pre_nxt    = '0;
          cycles_nxt = '0;
        end
      end

      RUN: begin
        if (bus.stop) state_nxt = HOLD;
        else          pre_nxt   = tick_en ? '0 : pre_cnt + 1'b1;
      end

      HOLD: begin
        if (bus.stop) begin
          state_nxt = IDLE;
        end else if (bus.start) begin
          state_nxt = RUN;
          pre_nxt   = '0;
        end
      end

      DONE: begin
        if (bus.stop) begin
          state_nxt = IDLE;
        end else if (bus.start) begin
          state_nxt  = RUN;
          q_nxt      = '0;
          pre_nxt    = '0;
          cycles_nxt = '0;
        end
      end

      default: state_nxt = IDLE;
    endcase

    // Ticks only happen in RUN without stop or in HOLD with a lone step; in
    // both cases the case above left state unchanged, so the chain advance and
    // the cycle bookkeeping can be layered on top.
    if (tick_en) q_nxt = q_adv;

    if (cyc_hit) begin
      cycles_nxt = cycles_inc;
      if ((bus.n_cycles != '0) && (cycles_inc == bus.n_cycles)) state_nxt = DONE;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= IDLE;
      q       <= '0;
      pre_cnt <= '0;
      cycles  <= '0;
    end else begin
      state   <= state_nxt;
      q       <= q_nxt;
      pre_cnt <= pre_nxt;
      cycles  <= cycles_nxt;
    end
  end

  assign bus.Q      = q;
  assign bus.tick   = tick_en;
  assign bus.cyc_ev = cyc_hit;
  assign bus.cycles = cycles;
  assign bus.busy   = (state == RUN) || (state == HOLD);
  assign bus.done   = (state == DONE);

  // ---------------------------------------------------------------------------
  // Invariants: ticks only while running or single-stepping, and every stage
  // always holds one of the eight legal Johnson codes.
  // ---------------------------------------------------------------------------
  function automatic logic is_johnson(input logic [3:0] s);
    return s inside {4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
  endfunction

  a_tick_state: assert property (@(posedge clk) disable iff (clr)
    tick_en |-> ((state == RUN) || (state == HOLD)));

  for (genvar g = 0; g < NSTAGE; g++) begin : g_legal
    a_legal_code: assert property (@(posedge clk) disable iff (clr)
      is_johnson(q[4*g +: 4]));
  end

endmodule

// File: tb/tb_jc_chain_sequencer.sv
// -----------------------------------------------------------------------------
// tb_jc_chain_sequencer
//
// Directed bench for jc_chain_sequencer. dut1 is a single-stage chain, dut2 a
// two-stage chain. Inputs change on the falling edge; outputs are sampled on
// the falling edge (or 1 time unit after an input change for the
// combinational tick). With SEQ_STEP_EN defined the step scenarios are
// exercised as well.
// -----------------------------------------------------------------------------
module tb_jc_chain_sequencer;

  logic clk;
  logic clr;

  int errors = 0;
  int checks = 0;

  jc_chain_sequencer_if #(.NSTAGE(1), .PRE_W(8), .CNT_W(8)) bus1 ();
  jc_chain_sequencer_if #(.NSTAGE(2), .PRE_W(8), .CNT_W(8)) bus2 ();

  jc_chain_sequencer #(.NSTAGE(1), .PRE_W(8), .CNT_W(8)) dut1 (
    .clk (clk),
    .clr (clr),
    .bus (bus1.slave)
  );

  jc_chain_sequencer #(.NSTAGE(2), .PRE_W(8), .CNT_W(8)) dut2 (
    .clk (clk),
    .clr (clr),
    .bus (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] seq [5];
    logic [3:0] q_held, q_resume, q_after;
    int         ev_n;
    int         ev_t [2];
    int         no_tick;
    int         spacing_bad;
    int         t;
    logic       done_seen;
    logic       hit;

    seq = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE};

    clr            = 1'b1;
    bus1.start     = 1'b0;
    bus1.stop      = 1'b0;
    bus1.pre_div   = '0;
    bus1.n_cycles  = '0;
    bus2.start     = 1'b0;
    bus2.stop      = 1'b0;
    bus2.pre_div   = '0;
    bus2.n_cycles  = '0;
`ifdef SEQ_STEP_EN
    bus1.step      = 1'b0;
    bus2.step      = 1'b0;
`endif

    // ---------------- reset state ----------------
    #1;
    check("rst_q",      bus1.Q,      0);
    check("rst_busy",   bus1.busy,   0);
    check("rst_done",   bus1.done,   0);
    check("rst_cycles", bus1.cycles, 0);
    check("rst_tick",   bus1.tick,   0);
    check("rst_cyc_ev", bus1.cyc_ev, 0);
    check("rst_q2",     bus2.Q,      0);

    @(negedge clk);
    clr = 1'b0;

    // start and stop together in IDLE: stop wins
    bus1.start = 1'b1;
    bus1.stop  = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    bus1.stop  = 1'b0;
    check("idle_start_stop_busy", bus1.busy, 0);

    // ---------------- single run, n_cycles=1 ----------------
    bus1.pre_div  = 8'd0;
    bus1.n_cycles = 8'd1;
    bus1.start    = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    check("run_entry_q",    bus1.Q,    0);
    check("run_entry_busy", bus1.busy, 1);
    check("run_entry_tick", bus1.tick, 1);
    for (int i = 0; i < 5; i++) begin
      check("run_cyc_ev", bus1.cyc_ev, (i == 4));
      @(negedge clk);
      check("run_q", bus1.Q, seq[i]);
    end
    check("run_done",   bus1.done,   1);
    check("run_busy",   bus1.busy,   0);
    check("run_cycles", bus1.cycles, 1);
    check("run_tick",   bus1.tick,   0);

    // DONE + stop -> IDLE, Q kept
    bus1.stop = 1'b1;
    @(negedge clk);
    bus1.stop = 1'b0;
    check("done_stop_done", bus1.done, 0);
    check("done_stop_busy", bus1.busy, 0);
    check("done_stop_q",    bus1.Q,    4'hE);

    // ---------------- async reset mid-RUN ----------------
    bus1.n_cycles = 8'd0;
    bus1.start    = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    repeat (3) @(negedge clk);
    check("arst_pre_q",    bus1.Q,    4'h7);
    check("arst_pre_busy", bus1.busy, 1);
    #2 clr = 1'b1;
    #1;
    check("arst_q",      bus1.Q,      0);
    check("arst_busy",   bus1.busy,   0);
    check("arst_done",   bus1.done,   0);
    check("arst_cycles", bus1.cycles, 0);
    check("arst_tick",   bus1.tick,   0);
    #1 clr = 1'b0;
    @(negedge clk);
    check("arst_idle_busy", bus1.busy, 0);
    check("arst_idle_q",    bus1.Q,    0);
    @(negedge clk);
    check("arst_idle_q2",   bus1.Q,    0);

    // ---------------- prescaler ----------------
    bus1.pre_div = 8'd3;
    bus1.start   = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("pre_tick", bus1.tick, (i == 3));
      check("pre_q",    bus1.Q,    0);
      @(negedge clk);
    end
    check("pre_first_q",   bus1.Q,    4'h1);
    check("pre_wrap_tick", bus1.tick, 0);
    @(negedge clk);
    check("pre_mid_tick",  bus1.tick, 0);
    bus1.pre_div = 8'd0;
    #1;
    check("pre_lower_tick", bus1.tick, 1);
    @(negedge clk);
    check("pre_lower_q",    bus1.Q,    4'h3);
    check("pre_every_tick", bus1.tick, 1);
    bus1.stop = 1'b1;
    repeat (2) @(negedge clk);
    bus1.stop = 1'b0;
    check("pre_end_busy", bus1.busy, 0);
    check("pre_end_q",    bus1.Q,    4'h3);

    // ---------------- pause / hold / step ----------------
    bus1.pre_div = 8'd0;
    bus1.start   = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    repeat (2) @(negedge clk);
    check("hold_run_q", bus1.Q, 4'h3);
    bus1.stop = 1'b1;
    #1;
    check("hold_stop_tick", bus1.tick, 0);
    @(negedge clk);
    bus1.stop = 1'b0;
    check("hold_q",    bus1.Q,    4'h3);
    check("hold_busy", bus1.busy, 1);
    repeat (10) @(negedge clk);
    check("hold_10_q",    bus1.Q,    4'h3);
    check("hold_10_tick", bus1.tick, 0);
    check("hold_10_busy", bus1.busy, 1);
`ifdef SEQ_STEP_EN
    bus1.step = 1'b1;
    #1;
    check("step_tick", bus1.tick, 1);
    @(negedge clk);
    bus1.step = 1'b0;
    check("step_q",    bus1.Q,    4'h7);
    check("step_busy", bus1.busy, 1);
    q_held   = 4'h7;
    q_resume = 4'hF;
    q_after  = 4'hE;
`else
    q_held   = 4'h3;
    q_resume = 4'h7;
    q_after  = 4'hF;
`endif
    bus1.start = 1'b1;
    #1;
    check("resume_hold_tick", bus1.tick, 0);
    @(negedge clk);
    bus1.start = 1'b0;
    check("resume_entry_q",    bus1.Q,    q_held);
    check("resume_entry_tick", bus1.tick, 1);
    @(negedge clk);
    check("resume_q", bus1.Q, q_resume);
`ifdef SEQ_STEP_EN
    bus1.step = 1'b1;
`endif
    @(negedge clk);
`ifdef SEQ_STEP_EN
    bus1.step = 1'b0;
`endif
    check("run_step_q", bus1.Q, q_after);
    bus1.stop = 1'b1;
    repeat (2) @(negedge clk);
    bus1.stop = 1'b0;
    check("hold_end_busy", bus1.busy, 0);
    check("hold_end_q",    bus1.Q,    q_after);

    // ---------------- two-stage cascade ----------------
    bus2.pre_div  = 8'd0;
    bus2.n_cycles = 8'd2;
    bus2.start    = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0;
    ev_n    = 0;
    no_tick = 0;
    for (int tk = 1; tk <= 101; tk++) begin
      if (tk == 37) check("casc_q_at_37", bus2.Q, 8'hFF);
      if (bus2.tick !== 1'b1) no_tick++;
      if (bus2.cyc_ev === 1'b1) begin
        if (ev_n < 2) ev_t[ev_n] = tk;
        ev_n++;
      end
      @(negedge clk);
      if (tk == 37) begin
        check("casc_cycles_37", bus2.cycles, 1);
        check("casc_busy_37",   bus2.busy,   1);
      end
    end
    check("casc_ev_count", ev_n, 2);
    check("casc_ev0",      ev_t[0], 37);
    check("casc_ev1",      ev_t[1], 101);
    check("casc_no_tick",  no_tick, 0);
    check("casc_done",     bus2.done,   1);
    check("casc_busy",     bus2.busy,   0);
    check("casc_q",        bus2.Q,      8'hEE);
    check("casc_cycles",   bus2.cycles, 2);

    // ---------------- free-run with counter wrap ----------------
    bus1.pre_div  = 8'd0;
    bus1.n_cycles = 8'd0;
    bus1.start    = 1'b1;
    @(negedge clk);
    bus1.start  = 1'b0;
    t           = 0;
    ev_n        = 0;
    spacing_bad = 0;
    done_seen   = 1'b0;
    while ((ev_n < 256) && (t < 2200)) begin
      t++;
      hit = 1'b0;
      if (bus1.cyc_ev === 1'b1) begin
        hit = 1'b1;
        ev_n++;
        if (t != 5 + 8 * (ev_n - 1)) spacing_bad++;
      end
      if (bus1.done !== 1'b0) done_seen = 1'b1;
      @(negedge clk);
      if (hit && (ev_n == 1))   check("free_cycles_1",   bus1.cycles, 1);
      if (hit && (ev_n == 255)) check("free_cycles_255", bus1.cycles, 255);
      if (hit && (ev_n == 256)) check("free_cycles_wrap", bus1.cycles, 0);
    end
    check("free_events",  ev_n,        256);
    check("free_spacing", spacing_bad, 0);
    check("free_no_done", done_seen,   0);
    check("free_busy",    bus1.busy,   1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jc_chain_sequencer.md
Name: jc_chain_sequencer

Overview:
Run/stop controller for a cascade of NSTAGE 4-bit Johnson counter stages.
- Stage update rule: Q <= {Q[2:0], ~Q[3]}. Stage terminal state (TC) is Q == 4'hF.
- A programmable prescaler generates the stage-0 count enable. Each later stage is enabled by the previous stage's CEO.
- The block counts complete chain cycles and stops after a programmed number of them.
- It sits between the control/test logic and the Johnson counter datapath, and provides the timing-phase sequences used by the lab designs.

Parameters:
- NSTAGE, 2, number of cascaded 4-bit Johnson stages (1..4).
- PRE_W, 8, prescaler divide field width.
- CNT_W, 8, chain-cycle counter width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- clr  in  1  asynchronous, active-high reset.
- start  in  1  start / resume request.
- stop  in  1  pause / abort request.
- step  in  1  single tick while paused (only with SEQ_STEP_EN).
- pre_div  in  PRE_W  tick period minus 1; read live.
- n_cycles  in  CNT_W  number of chain cycles to run; 0 = free-run.
- Q  out  4*NSTAGE  chain state; stage k occupies Q[4k+3:4k].
- tick  out  1  stage-0 enable for the current cycle (combinational).
- cyc_ev  out  1  last-stage CEO for the current cycle (combinational).
- cycles  out  CNT_W  completed chain cycles.
- busy  out  1  high in RUN or HOLD.
- done  out  1  high in DONE.

Behaviour:
- Reset (clr=1, asynchronous): state=IDLE, Q=0, pre_cnt=0, cycles=0; tick=cyc_ev=busy=done=0. Reset dominates every other input, including mid-RUN.
- FSM states: IDLE, RUN, HOLD, DONE.
- Same-cycle input priority: stop > start > step.
- FSM transitions:
  - IDLE + start: Q<=0, cycles<=0, pre_cnt<=0, go to RUN.
  - RUN + stop: go to HOLD; Q, cycles and pre_cnt are frozen.
  - RUN + start: ignored.
  - HOLD + start: pre_cnt<=0, go to RUN; Q and cycles are kept.
  - HOLD + stop: go to IDLE; Q and cycles are kept.
  - DONE + start: same as IDLE + start.
  - DONE + stop: go to IDLE.
  - IDLE + stop: stay in IDLE. IDLE with start and stop together: stop wins, stay in IDLE.
- Prescaler (RUN only):
  - pre_cnt increments every clk.
  - When pre_cnt >= pre_div: tick=1 that cycle and pre_cnt<=0. The >= compare covers pre_div lowered below pre_cnt.
  - pre_div=0 gives a tick on every RUN cycle.
  - First tick occurs on the (pre_div+1)th RUN cycle after entry.
- Chain enables:
  - ce0 = tick.
  - ce_k = ce_(k-1) & (stage k-1 == 4'hF).
  - A stage updates only when its ce is high.
  - cyc_ev = ce_(NSTAGE-1) & (last stage == 4'hF).
  - cyc_ev fires once per 8^NSTAGE ticks. For NSTAGE=1 it first fires on tick 5; for NSTAGE=2 on tick 37 (ticks counted from start).
- Cycle counter: on cyc_ev, cycles<=cycles+1, wrapping modulo 2^CNT_W.
  - If n_cycles != 0 and cycles+1 == n_cycles: go to DONE on the same edge. The chain still advances on that tick.
  - If n_cycles == 0: never go to DONE.
- Non-Johnson Q values cannot occur; Q is only ever loaded with 0 or advanced by the update rule.
- tick and cyc_ev are 0 in IDLE and DONE.

Optional Feature:
SEQ_STEP_EN
- Defined:
  - The step port exists.
  - In HOLD, step=1 (with stop=start=0) drives tick=1 for that cycle. The chain advances one tick, and cyc_ev / cycles / DONE are processed exactly as in RUN. pre_cnt is unchanged.
  - step is ignored in all other states.
- Undefined: the step port is absent and HOLD never ticks.

Test Plan:
- Async reset: NSTAGE=1, RUN with Q=4'h7; pulse clr between edges -> Q=0, busy=0, done=0, cycles=0 immediately, before the next edge; after release, block stays in IDLE.
- Single run: NSTAGE=1, pre_div=0, n_cycles=1; start for 1 cycle.
  - Q over successive edges: 1, 3, 7, F, E.
  - cyc_ev high on 5th tick; after it done=1, busy=0, cycles=1, Q=4'hE.
- Prescale: pre_div=3 -> tick every 4th cycle; first Q change 4 edges after RUN entry; lower pre_div to 0 mid-count -> tick on the next cycle.
- Cascade: NSTAGE=2, pre_div=0, n_cycles=2 -> cyc_ev on ticks 37 and 101; done after tick 101 with Q=8'hEE, cycles=2.
- Pause/step (SEQ_STEP_EN): NSTAGE=1, pre_div=0.
  - Run 2 ticks (Q=3), then stop -> Q stays 3 for 10 cycles.
  - 1-cycle step -> Q=7.
  - start -> resumes, next Q=F.
  - step in RUN -> no extra advance.
- Free-run: NSTAGE=1, pre_div=0, n_cycles=0 -> done never asserts; cycles increments every 8 ticks and wraps 255 -> 0 after 256 cycle events.
